// File: rtl/regfile8_16b.sv
// -----------------------------------------------------------------------------
// regfile8_16b
//   8-entry x 16-bit register file. It has two combinational read ports, one
//   synchronous write port and a per-register busy scoreboard that the control
//   unit uses to detect hazards.
//   Register r0 always reads as zero and can never be reserved.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ra_addr/ra_data     read port A (write-through bypass from wr_*)
//   rb_addr/rb_data     read port B (write-through bypass from wr_*)
//   wr_en/wr_addr/wr_data   writeback port; also retires the busy bit
//   rsv_en/rsv_addr     reserve request; marks the destination busy
//   ra_busy/rb_busy     busy bit of the register addressed by each read port
//   busy_vec            full scoreboard, bit i = register i busy
//   rsv_err             one-cycle pulse: reserve hit an already-busy register
//   r0_q..r7_q          registered contents, exported to mux8_16b a..h
// -----------------------------------------------------------------------------
module regfile8_16b #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ra_addr,
    input  logic [2:0]       rb_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rsv_en,
    input  logic [2:0]       rsv_addr,
    output logic             ra_busy,
    output logic             rb_busy,
    output logic [DEPTH-1:0] busy_vec,
    output logic             rsv_err,
    output logic [WIDTH-1:0] r0_q,
    output logic [WIDTH-1:0] r1_q,
    output logic [WIDTH-1:0] r2_q,
    output logic [WIDTH-1:0] r3_q,
    output logic [WIDTH-1:0] r4_q,
    output logic [WIDTH-1:0] r5_q,
    output logic [WIDTH-1:0] r6_q,
    output logic [WIDTH-1:0] r7_q
);

    logic [WIDTH-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0] busy_r;
    logic             rsv_err_r;

    logic [DEPTH-1:0] wr_hit_s;
    logic [DEPTH-1:0] rsv_hit_s;
    logic [DEPTH-1:0] busy_nxt_s;
    logic             rsv_err_nxt_s;
    logic             byp_a_s;
    logic             byp_b_s;

    // One-hot decode of write and reserve targets. Bit 0 never fires, so r0
    // can never be written or marked busy.
    always_comb begin
        wr_hit_s  = {DEPTH{1'b0}};
        rsv_hit_s = {DEPTH{1'b0}};
        for (int i = 1; i < DEPTH; i++) begin
            wr_hit_s[i]  = wr_en  && (wr_addr  == 3'(i));
            rsv_hit_s[i] = rsv_en && (rsv_addr == 3'(i));
        end
    end

    // Scoreboard next state. A reserve takes priority over a same-cycle
    // retire. A reserve is an error only when the target stays busy, meaning
    // no write retires the old producer on the same edge.
    always_comb begin
        busy_nxt_s    = (busy_r & ~wr_hit_s) | rsv_hit_s;
        rsv_err_nxt_s = |(rsv_hit_s & busy_r & ~wr_hit_s);
    end

    // Register array, scoreboard and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
            busy_r    <= {DEPTH{1'b0}};
            rsv_err_r <= 1'b0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_hit_s[i]) begin
                    regs_r[i] <= wr_data;
                end
            end
            busy_r    <= busy_nxt_s;
            rsv_err_r <= rsv_err_nxt_s;
        end
    end

    // Write-through bypass detection. It is gated by rst_n so that a write
    // discarded by reset is not visible on the read ports either.
    always_comb begin
        byp_a_s = rst_n && wr_en && (wr_addr != 3'd0) && (wr_addr == ra_addr);
        byp_b_s = rst_n && wr_en && (wr_addr != 3'd0) && (wr_addr == rb_addr);
    end

    // Read ports. A bypassed register has its producer retiring this cycle,
    // so the port reports it as not busy.
    always_comb begin
        ra_data = (ra_addr == 3'd0) ? {WIDTH{1'b0}} :
                  (byp_a_s ? wr_data : regs_r[ra_addr]);
        rb_data = (rb_addr == 3'd0) ? {WIDTH{1'b0}} :
                  (byp_b_s ? wr_data : regs_r[rb_addr]);
        ra_busy = !byp_a_s && busy_r[ra_addr];
        rb_busy = !byp_b_s && busy_r[rb_addr];
    end

    assign busy_vec = busy_r;
    assign rsv_err  = rsv_err_r;
    assign r0_q     = regs_r[0];
    assign r1_q     = regs_r[1];
    assign r2_q     = regs_r[2];
    assign r3_q     = regs_r[3];
    assign r4_q     = regs_r[4];
    assign r5_q     = regs_r[5];
    assign r6_q     = regs_r[6];
    assign r7_q     = regs_r[7];

endmodule

// File: tb/tb_regfile8_16b.sv
// -----------------------------------------------------------------------------
// tb_regfile8_16b
//   Scoreboard bench for regfile8_16b. Each stimulus cycle pushes the expected
//   pre-edge view of the outputs, computed from a behavioural model. A monitor
//   on the falling edge pops that entry and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_regfile8_16b;

    logic        clk;
    logic        rst_n;
    logic [2:0]  ra_addr, rb_addr, wr_addr, rsv_addr;
    logic [15:0] ra_data, rb_data, wr_data;
    logic        wr_en, rsv_en, ra_busy, rb_busy, rsv_err;
    logic [7:0]  busy_vec;
    logic [15:0] dq [8];

    regfile8_16b dut (
        .clk(clk), .rst_n(rst_n),
        .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_data), .rb_data(rb_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .ra_busy(ra_busy), .rb_busy(rb_busy),
        .busy_vec(busy_vec), .rsv_err(rsv_err),
        .r0_q(dq[0]), .r1_q(dq[1]), .r2_q(dq[2]), .r3_q(dq[3]),
        .r4_q(dq[4]), .r5_q(dq[5]), .r6_q(dq[6]), .r7_q(dq[7])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]      ra_data;
        logic [15:0]      rb_data;
        logic             ra_busy;
        logic             rb_busy;
        logic [7:0]       busy_vec;
        logic             rsv_err;
        logic [7:0][15:0] q;
    } exp_t;

    exp_t sb_q [$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model: register contents, busy flags, last error pulse.
    logic [15:0] m_regs [8];
    logic        m_busy [8];
    logic        m_err;
    // Inputs issued in the current cycle; the model applies them at the next edge.
    logic        p_we, p_re;
    logic [2:0]  p_wa, p_rsa;
    logic [15:0] p_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = 16'h0000;
            m_busy[i] = 1'b0;
        end
        m_err = 1'b0;
        p_we = 1'b0; p_re = 1'b0; p_wa = 3'd0; p_rsa = 3'd0; p_wd = 16'h0000;
    endtask

    // Apply one clock edge of architectural rules to the model.
    task automatic model_apply();
        m_err = p_re && (p_rsa != 3'd0) && m_busy[p_rsa] && !(p_we && (p_wa == p_rsa));
        if (p_we && (p_wa != 3'd0)) begin
            m_regs[p_wa] = p_wd;
            m_busy[p_wa] = 1'b0;
        end
        if (p_re && (p_rsa != 3'd0)) begin
            m_busy[p_rsa] = 1'b1;
        end
    endtask

    // One stimulus cycle: advance the model, drive inputs, queue expectations.
    task automatic step(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic re, input logic [2:0] rsa,
                        input logic [2:0] raa, input logic [2:0] rba);
        exp_t e;
        logic ba, bb;
        @(posedge clk);
        #1;
        model_apply();
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = rsa; ra_addr = raa; rb_addr = rba;
        ba = we && (wa != 3'd0) && (wa == raa);
        bb = we && (wa != 3'd0) && (wa == rba);
        e.ra_data = (raa == 3'd0) ? 16'h0000 : (ba ? wd : m_regs[raa]);
        e.rb_data = (rba == 3'd0) ? 16'h0000 : (bb ? wd : m_regs[rba]);
        e.ra_busy = !ba && m_busy[raa];
        e.rb_busy = !bb && m_busy[rba];
        for (int i = 0; i < 8; i++) begin
            e.busy_vec[i] = m_busy[i];
            e.q[i]        = m_regs[i];
        end
        e.rsv_err = m_err;
        sb_q.push_back(e);
        p_we = we; p_wa = wa; p_wd = wd; p_re = re; p_rsa = rsa;
    endtask

    // Monitor: compares the DUT with the oldest expectation each falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("ra_data",  {16'h0000, ra_data},  {16'h0000, e.ra_data});
            chk("rb_data",  {16'h0000, rb_data},  {16'h0000, e.rb_data});
            chk("ra_busy",  {31'd0, ra_busy},     {31'd0, e.ra_busy});
            chk("rb_busy",  {31'd0, rb_busy},     {31'd0, e.rb_busy});
            chk("busy_vec", {24'd0, busy_vec},    {24'd0, e.busy_vec});
            chk("rsv_err",  {31'd0, rsv_err},     {31'd0, e.rsv_err});
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("r%0d_q", i), {16'h0000, dq[i]}, {16'h0000, e.q[i]});
            end
        end
    end

    task automatic rand_step();
        step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
             1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    endtask

    initial begin
        logic [15:0] mux_o;
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000;
        rsv_en = 1'b0; rsv_addr = 3'd0; ra_addr = 3'd1; rb_addr = 3'd2;
        model_reset();
        #12;
        chk("reset_busy_vec", {24'd0, busy_vec}, 32'd0);
        chk("reset_rsv_err",  {31'd0, rsv_err},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write / read, r0 hardwired zero.
        step(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd0, 3'd0);
        step(1'b1, 3'd7, 16'h1234, 1'b0, 3'd0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd7);
        step(1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0);
        // Bypass on r5.
        step(1'b1, 3'd5, 16'h0001, 1'b0, 3'd0, 3'd0, 3'd0);
        step(1'b1, 3'd5, 16'hA5A5, 1'b0, 3'd0, 3'd5, 3'd5);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd0);
        // Scoreboard on r2: reserve, double reserve (error), retire.
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd2, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd2, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd0);
        step(1'b1, 3'd2, 16'h2222, 1'b0, 3'd0, 3'd0, 3'd2);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd0);
        // Same-cycle write+reserve of busy r4; reserve of r0.
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd4, 3'd0);
        step(1'b1, 3'd4, 16'h4444, 1'b1, 3'd4, 3'd4, 3'd4);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd4, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0);

        for (int n = 0; n < 400; n++) rand_step();
        for (int i = 1; i < 8; i++) step(1'b1, 3'(i), 16'hF0F0 ^ 16'(i), 1'b1, 3'(i), 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0);

        // Asynchronous reset mid-cycle with a write in flight.
        @(posedge clk);
        #3;
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'hFFFF;
        ra_addr = 3'd6; rb_addr = 3'd3;
        rst_n = 1'b0;
        #1;
        chk("rst_ra_data",  {16'h0000, ra_data}, 32'd0);
        chk("rst_rb_data",  {16'h0000, rb_data}, 32'd0);
        chk("rst_busy_vec", {24'd0, busy_vec},   32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("rst_r%0d_q", i), {16'h0000, dq[i]}, 32'd0);
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        model_reset();

        // Mux integration: r1..r7 = 1..7, then sweep a bench-side 8:1 mux.
        for (int i = 1; i < 8; i++) step(1'b1, 3'(i), 16'(i), 1'b0, 3'd0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0);
        @(negedge clk);
        #1;
        for (int s = 0; s < 8; s++) begin
            case (s)
                0: mux_o = dq[0];
                1: mux_o = dq[1];
                2: mux_o = dq[2];
                3: mux_o = dq[3];
                4: mux_o = dq[4];
                5: mux_o = dq[5];
                6: mux_o = dq[6];
                default: mux_o = dq[7];
            endcase
            chk($sformatf("mux_sel%0d", s), {16'h0000, mux_o}, 32'(s));
        end

        for (int n = 0; n < 100; n++) rand_step();

        for (int n = 0; n < 20; n++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries left expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
